sipo_dram: RTL

SIPO_DRAM -- requirements
Module: sipo_dram

---
 rtl/sipo_dram_pkg.sv | 18 +
 rtl/sat_counter16.sv | 20 ++
 rtl/sipo_dram.sv | 119 +++++++++++
 3 files changed

// File: rtl/sipo_dram_pkg.sv
// Shared definitions for the DRAM readout blocks: serial-to-parallel FSM
// states, statistics counter width and saturation value, lane-width helper.
package sipo_dram_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } sipo_state_t;

    localparam int unsigned SAT_W = 16;
    localparam logic [SAT_W-1:0] SAT_MAX = 16'hFFFF;

    // Lane counter width; at least one bit so a single-lane word still has a counter.
    function automatic int unsigned lane_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum value.
module sat_counter16
    import sipo_dram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [SAT_W-1:0] count
);

    // Count increment requests, holding at SAT_MAX once reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != SAT_MAX)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/sipo_dram.sv
// Serial-to-parallel word assembler feeding a FIFO, with a one-word holding
// register to ride out back-pressure, plus drop/resync statistics.
module sipo_dram
    import sipo_dram_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = 8,
    parameter int unsigned OUTPUT_SIZE = 288
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INPUT_SIZE-1:0]  i_serial,
    input  logic                   i_valid,
    input  logic                   i_sof,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic [OUTPUT_SIZE-1:0] o_parallel,
    output logic                   overflow,
    output logic [SAT_W-1:0]       drop_count,
    output logic [SAT_W-1:0]       resync_count
);

    localparam int unsigned WORDS = OUTPUT_SIZE / INPUT_SIZE;
    localparam int unsigned LW    = lane_width(WORDS);
    localparam logic [LW-1:0] LAST_LANE = LW'(WORDS - 1);

    sipo_state_t            state;
    logic [LW-1:0]          cnt;
    logic [LW-1:0]          lane;
    logic [LW-1:0]          cnt_next;
    logic [OUTPUT_SIZE-1:0] asm_buf;
    logic [OUTPUT_SIZE-1:0] asm_next;
    logic [OUTPUT_SIZE-1:0] hold;
    logic                   accept;
    logic                   complete;
    logic                   resync_inc;
    logic                   drop_inc;

    // Byte placement: next assembly buffer, next lane, word completion and resync events.
    always_comb begin
        accept     = ce && i_valid;
        lane       = i_sof ? '0 : cnt;
        asm_next   = asm_buf;
        cnt_next   = cnt;
        complete   = 1'b0;
        resync_inc = 1'b0;
        if (accept) begin
            // A start-of-word byte wipes any partial word before landing in lane 0.
            if (i_sof) begin
                asm_next = '0;
            end
            asm_next[lane*INPUT_SIZE +: INPUT_SIZE] = i_serial;
            complete   = (lane == LAST_LANE);
            cnt_next   = complete ? '0 : lane + 1'b1;
            resync_inc = i_sof && (cnt != '0);
        end
        drop_inc = (state == PEND) && fifo_full && complete;
    end

    // Assembly state, hold register and write-strobe FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            cnt        <= '0;
            asm_buf    <= '0;
            hold       <= '0;
            fifo_we    <= 1'b0;
            o_parallel <= '0;
            overflow   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            asm_buf <= asm_next;
            fifo_we <= 1'b0;
            case (state)
                FILL: begin
                    if (complete) begin
                        hold <= asm_next;
                        if (!fifo_full) begin
                            fifo_we    <= 1'b1;
                            o_parallel <= asm_next;
                        end else begin
                            state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (!fifo_full) begin
                        fifo_we    <= 1'b1;
                        o_parallel <= hold;
                        // Draining and completing together: new word takes the hold slot.
                        if (complete) begin
                            hold <= asm_next;
                        end else begin
                            state <= FILL;
                        end
                    end else if (complete) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

    sat_counter16 u_resync_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resync_inc),
        .count (resync_count)
    );

endmodule
